// File: rtl/rr_arbiter8_pkg.sv
// Types and helpers for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
    `include "arb_defs.vh"

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/arb_defs.vh
// Arbiter constants shared by the rr_arbiter8 slice: requester count, index width, state codes.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH
localparam int   N_REQ    = 8;
localparam int   ID_W     = 3;
localparam logic ST_IDLE  = 1'b0;
localparam logic ST_GRANT = 1'b1;
`endif

// File: rtl/or8way_gate.sv
// Gate-library 8-input OR reduction.
module or8way_gate (
    input  logic [7:0] a,
    output logic       y
);
    assign y = |a;
endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping 7->0.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    pos;

    // Rotate so that bit 0 of rot is req[start], then priority-encode the lowest set bit.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N_REQ-1:0];

    always_comb begin
        // NOTE: default first so every path assigns pos and no latch is inferred.
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = ID_W'(i);
        end
    end

    assign found = |rot;
    assign idx   = start + pos;
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and optional hold budget.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_req
);
    localparam bit               PREEMPT   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [CNT_W-1:0]  hold_cnt;
    logic [ID_W-1:0]   start;
    logic [N_REQ-1:0]  others;
    logic              a_found, b_found;
    logic [ID_W-1:0]   a_idx, b_idx;
    logic              expired;

    or8way_gate u_any (.a(req), .y(any_req));

    // While granting, last_id equals the holder, so one start index serves both pickers.
    assign start   = last_id + ID_W'(1);
    assign others  = req & ~onehot(grant_id);
    assign expired = PREEMPT && (hold_cnt == HOLD_LAST);

    rr_pick8 u_pick_all (.req(req),    .start(start), .found(a_found), .idx(a_idx));
    rr_pick8 u_pick_oth (.req(others), .start(start), .found(b_found), .idx(b_idx));

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_id     <= ID_W'(N_REQ - 1);
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_found) begin
                        state       <= GRANT;
                        grant       <= onehot(a_idx);
                        grant_valid <= 1'b1;
                        grant_id    <= a_idx;
                        last_id     <= a_idx;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        hold_cnt <= '0;
                        if (a_found) begin
                            grant    <= onehot(a_idx);
                            grant_id <= a_idx;
                            last_id  <= a_idx;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                        end
                    end else if (expired) begin
                        // A lone holder simply restarts its budget without losing the grant.
                        hold_cnt <= '0;
                        if (b_found) begin
                            grant    <= onehot(b_idx);
                            grant_id <= b_idx;
                            last_id  <= b_idx;
                        end
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_valid:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
    a_id:     assert property (@(posedge clk) disable iff (!rst_n)
                               grant_valid |-> grant == onehot(grant_id));
endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: reference model for MAX_HOLD=4 plus directed MAX_HOLD=0 checks.
module tb_rr_arbiter8;
    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req, req2;
    logic [7:0] grant, grant2;
    logic       grant_valid, grant_valid2;
    logic [2:0] grant_id, grant_id2;
    logic       any_req, any_req2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    bit m_busy;
    int m_gid, m_last, m_cnt;

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .grant_valid(grant_valid), .grant_id(grant_id), .any_req(any_req)
    );

    rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(3)) dut_nohold (
        .clk(clk), .rst_n(rst_n), .req(req2), .grant(grant2),
        .grant_valid(grant_valid2), .grant_id(grant_id2), .any_req(any_req2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input logic [7:0] r, input int from);
        for (int k = 0; k < 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rs);
        int w;
        if (!rs) begin
            m_busy = 0; m_gid = 0; m_last = 7; m_cnt = 0;
        end else if (!m_busy) begin
            w = search(r, m_last + 1);
            if (w >= 0) begin m_busy = 1; m_gid = w; m_last = w; m_cnt = 0; end
        end else if (!r[m_gid]) begin
            w = search(r, m_gid + 1);
            m_cnt = 0;
            if (w >= 0) begin m_gid = w; m_last = w; end
            else begin m_busy = 0; m_gid = 0; end
        end else if (m_cnt == 3) begin
            logic [7:0] oth;
            oth = r;
            oth[m_gid] = 1'b0;
            w = search(oth, m_gid + 1);
            m_cnt = 0;
            if (w >= 0) begin m_gid = w; m_last = w; end
        end else if (m_cnt < 7) begin
            m_cnt++;
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic rs, input logic [7:0] r2);
        exp_t e;
        @(negedge clk);
        req = r; req2 = r2; rst_n = rs;
        #1;
        check("any_req", any_req, |r);
        model_step(r, rs);
        e.g  = m_busy ? 8'(1 << m_gid) : 8'h00;
        e.v  = m_busy;
        e.id = 3'(m_gid);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("grant/valid/id", {grant, grant_valid, grant_id}, e);
    endtask

    initial begin
        logic [7:0] r;
        req = '0; req2 = '0; rst_n = 1'b0;

        cycle(8'h00, 0, 8'h00);
        cycle(8'h00, 0, 8'h00);
        check("reset_grant", grant, 8'h00);

        // Full load: rotation 0,1,2,... with 4-cycle tenures.
        for (int i = 0; i < 40; i++) cycle(8'hFF, 1, 8'h00);
        cycle(8'h00, 1, 8'h00);
        cycle(8'h00, 1, 8'h00);

        // Single requester through several expiry points.
        for (int i = 0; i < 10; i++) begin
            cycle(8'h20, 1, 8'h00);
            check("single_id", grant_id, 3'd5);
        end
        cycle(8'h00, 1, 8'h00);
        check("single_drop", grant_valid, 1'b0);

        // Release handover 2 -> 6, then back to idle.
        cycle(8'h04, 1, 8'h00);
        cycle(8'h44, 1, 8'h00);
        cycle(8'h40, 1, 8'h00);
        check("handover_grant", grant, 8'h40);
        cycle(8'h00, 1, 8'h00);
        check("handover_idle", grant, 8'h00);

        // Wrap-around: holder 6, then 7, then 0.
        cycle(8'h40, 1, 8'h00);
        cycle(8'h81, 1, 8'h00);
        check("wrap_7", grant_id, 3'd7);
        cycle(8'h01, 1, 8'h00);
        check("wrap_0", grant_id, 3'd0);
        cycle(8'h00, 1, 8'h00);

        // Reset while requester 3 holds the grant.
        cycle(8'h08, 1, 8'h00);
        check("pre_reset", grant, 8'h08);
        cycle(8'h08, 0, 8'h00);
        check("mid_reset", grant, 8'h00);
        cycle(8'h09, 1, 8'h00);
        check("post_reset", grant, 8'h01);
        cycle(8'h00, 1, 8'h00);

        // Random traffic with sticky requests and occasional resets.
        r = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom & $urandom);
            cycle(r, ($urandom_range(0, 49) != 0), 8'h00);
        end

        // Unlimited-hold build: requester 0 is never preempted.
        cycle(8'h00, 0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cycle(8'h00, 1, 8'h03);
            check("nohold_grant", grant2, 8'h01);
        end
        cycle(8'h00, 1, 8'h02);
        check("nohold_handover", grant2, 8'h02);
        check("nohold_id", grant_id2, 3'd1);
        cycle(8'h00, 1, 8'h00);
        check("nohold_idle", grant_valid2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Uses the existing 8-input OR-reduce gate for any-request detection.
- Issues a registered one-hot grant and holds it until the holder releases or its hold budget expires.
- Sits in front of any single-ported shared datapath in the gate library, such as a shared register or ALU.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one holder keeps the grant while others wait; 0 = unlimited (no preemption).
- CNT_W, 3, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req  input  8  request vector; bit i = requester i.
- grant  output  8  registered one-hot grant (all-zero when idle).
- grant_valid  output  1  registered; 1 iff grant != 0.
- grant_id  output  3  registered binary index of holder; 0 when idle.
- any_req  output  1  combinational OR of req[7:0].

Behaviour:
- One clock, synchronous active-low reset: all state changes on the rising edge of clk; rst_n sampled only there.
- Reset values:
  - grant = 8'h00, grant_valid = 0, grant_id = 0.
  - State = IDLE, hold_cnt = 0.
  - last_id = 7, so requester 0 has top priority after reset.
- Reset mid-grant drops the grant on that edge; there is no release handshake.
- States are IDLE and GRANT, held in a 1-bit register.
- Round-robin pick:
  - Search req starting at index (last_id+1) mod 8, ascending, wrapping 7->0.
  - The first set bit wins.
  - Implementation choice is free: rotate, priority-encode, un-rotate.
- IDLE:
  - If any_req = 1: load grant with the winner, set grant_id and last_id = winner, hold_cnt = 0, go to GRANT.
  - Latency is 1 cycle from req sampled high to grant high.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge with holder h = grant_id:
  - Release: req[h] = 0.
    - Re-arbitrate over req & ~(1<<h) starting at h+1.
    - If a winner exists, grant it on the same edge: back-to-back handover, no idle bubble.
    - Otherwise grant <= 0 and go to IDLE.
  - Expiry: MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and req & ~(1<<h) != 0.
    - Preempt: grant the round-robin winner among the others; hold_cnt = 0.
  - Expiry with no other requester: keep h and reset hold_cnt to 0. No spurious deassert.
  - Otherwise keep the grant and increment hold_cnt, saturating at 2^CNT_W-1.
- Release and expiry on the same edge are handled as release.
- A requester raising req in the cycle its grant is revoked is not re-granted ahead of others; the pointer has already advanced.
- Invariants (assertion-checked):
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id matches grant whenever grant_valid = 1.
- The outputs never glitch: grant, grant_valid and grant_id are registered. any_req is the only combinational output.

Decomposition:
- Shared `include header (arb_defs.vh) holds the arbiter constants: N_REQ = 8, ID_W = 3, and the state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1.
- One sub-module, rr_pick8: purely combinational.
  - Inputs: 8-bit request, 3-bit start index.
  - Outputs: found flag and 3-bit winner index.
  - Instantiated twice: once for the IDLE/release pick, once for the expiry pick with the holder masked.
- any_req uses the existing 8-input OR gate module (or8way_gate) rather than new logic.

Test Plan:
- Reset, then req = 8'hFF held.
  - Grants rotate 0,1,2,... with each holder lasting 4 cycles (MAX_HOLD = 4).
  - Handovers are back-to-back with no idle cycle, and grant is one-hot throughout.
- Single requester: req = 8'h20 for 10 cycles, then 0.
  - Grant 8'h20 and grant_id = 5 from cycle 1, continuous through expiry points with no gap.
  - grant returns to 0 and grant_valid to 0 one edge after req drops.
- Release handover: holder 2 drops req while req[6] = 1.
  - Next edge grant = 8'h40, grant_id = 6.
  - Then req[6] drops with no other requests: grant = 0 next edge and state returns to IDLE.
- Wrap-around: last_id = 6, req = 8'h81.
  - Winner is 7; after release the winner is 0, not 7 again.
- Reset mid-grant: rst_n = 0 for one edge while grant = 8'h08.
  - grant = 0 on that edge.
  - After release of reset with req = 8'h09, the winner is 0 (pointer reset to 7).
- MAX_HOLD = 0 build: req = 8'h03 held for 20 cycles.
  - Requester 0 keeps the grant all 20 cycles (no preemption).
  - Dropping req[0] hands the grant to 1 on the next edge.
